// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore main FSM sequencing fetch/decode/execute/memory/writeback,
// plus the combinational ALU decoder that turns ALUOp and Funct into ULAControle.
module mips_multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ULAControle,
   output logic [1:0] PCSrc,
   output logic       Branch,
   output logic       PCWrite
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
   } state_t;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

   state_t     state, state_n;
   logic [1:0] alu_op;

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= FETCH;
      else       state <= state_n;

   always_comb begin
      state_n  = FETCH;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      alu_op   = 2'b00;
      PCSrc    = 2'b00;
      Branch   = 1'b0;
      PCWrite  = 1'b0;
      case (state)
         FETCH: begin
            state_n = DECODE;
            ALUSrcB = 2'b01;
            IRWrite = 1'b1;
            PCWrite = 1'b1;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            state_n = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                      (Opcode == OP_R)    ? RTYPEEX :
                      (Opcode == OP_BEQ)  ? BEQEX :
                      (Opcode == OP_ADDI) ? ADDIEX :
                      (Opcode == OP_J)    ? JEX : FETCH;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_n = (Opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD    = 1'b1;
            state_n = MEMWB;
         end
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         RTYPEEX: begin
            ALUSrcA = 1'b1;
            alu_op  = 2'b10;
            state_n = RTYPEWB;
         end
         RTYPEWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BEQEX: begin
            ALUSrcA = 1'b1;
            alu_op  = 2'b01;
            PCSrc   = 2'b01;
            Branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_n = ADDIWB;
         end
         ADDIWB: RegWrite = 1'b1;
         JEX: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
         end
         default: state_n = FETCH;
      endcase
   end

   // Unknown Funct codes and the unused ALUOp 11 both fall back to add.
   always_comb
      ULAControle = (alu_op == 2'b01) ? 3'b110 :
                    (alu_op != 2'b10) ? 3'b010 :
                    (Funct == 6'b100010) ? 3'b110 :
                    (Funct == 6'b100100) ? 3'b000 :
                    (Funct == 6'b100101) ? 3'b001 :
                    (Funct == 6'b101010) ? 3'b111 : 3'b010;
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: table-driven instruction walks plus reset corner sequences.
module tb_mips_multicycle_controller;
   logic       clk, reset;
   logic [5:0] Opcode, Funct;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ULAControle;

   mips_multicycle_controller dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ULAControle(ULAControle), .PCSrc(PCSrc), .Branch(Branch), .PCWrite(PCWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ULAControle,PCSrc,Branch,PCWrite}
   logic [15:0] outs;
   assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ULAControle, PCSrc, Branch, PCWrite};

   localparam logic [15:0] E_FETCH   = {7'b0010000, 2'b01, 3'b010, 2'b00, 2'b01};
   localparam logic [15:0] E_DECODE  = {7'b0000000, 2'b11, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_MEMADR  = {7'b0000001, 2'b10, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_MEMRD   = {7'b1000000, 2'b00, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_MEMWB   = {7'b0000110, 2'b00, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_MEMWR   = {7'b1100000, 2'b00, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_RTYPEWB = {7'b0001010, 2'b00, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_BEQEX   = {7'b0000001, 2'b00, 3'b110, 2'b01, 2'b10};
   localparam logic [15:0] E_ADDIEX  = {7'b0000001, 2'b10, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_ADDIWB  = {7'b0000010, 2'b00, 3'b010, 2'b00, 2'b00};
   localparam logic [15:0] E_JEX     = {7'b0000000, 2'b00, 3'b010, 2'b10, 2'b01};

   function automatic logic [15:0] e_rtypeex(input logic [2:0] ula);
      return {7'b0000001, 2'b00, ula, 2'b00, 2'b00};
   endfunction

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] exp);
      vec_t v;
      v.op = op;
      v.fn = fn;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [15:0] exp);
      n_vec++;
      if (outs !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs=%b required=%b", nm, outs, exp);
      end
   endtask

   task automatic step(input string nm, input logic [15:0] exp);
      #1 chk(nm, exp);
      @(negedge clk);
   endtask

   task automatic rtype(input logic [5:0] fn, input logic [2:0] ula);
      add(6'b000000, fn, E_FETCH);
      add(6'b000000, fn, E_DECODE);
      add(6'b000000, fn, e_rtypeex(ula));
      add(6'b000000, fn, E_RTYPEWB);
   endtask

   initial begin
      add(6'b100011, 6'd0, E_FETCH);
      add(6'b100011, 6'd0, E_DECODE);
      add(6'b100011, 6'd0, E_MEMADR);
      add(6'b100011, 6'd0, E_MEMRD);
      add(6'b100011, 6'd0, E_MEMWB);
      add(6'b101011, 6'd0, E_FETCH);
      add(6'b101011, 6'd0, E_DECODE);
      add(6'b101011, 6'd0, E_MEMADR);
      add(6'b101011, 6'd0, E_MEMWR);
      rtype(6'b100000, 3'b010);
      rtype(6'b100010, 3'b110);
      rtype(6'b100100, 3'b000);
      rtype(6'b100101, 3'b001);
      rtype(6'b101010, 3'b111);
      rtype(6'b111111, 3'b010);
      add(6'b000100, 6'd0, E_FETCH);
      add(6'b000100, 6'b100101, E_DECODE);
      add(6'b000100, 6'b100101, E_BEQEX);
      add(6'b000010, 6'd0, E_FETCH);
      add(6'b000010, 6'd0, E_DECODE);
      add(6'b000010, 6'd0, E_JEX);
      add(6'b001000, 6'd0, E_FETCH);
      add(6'b001000, 6'd0, E_DECODE);
      add(6'b001000, 6'b100010, E_ADDIEX);
      add(6'b001000, 6'd0, E_ADDIWB);
      add(6'b111111, 6'd0, E_FETCH);
      add(6'b111111, 6'd0, E_DECODE);
      add(6'b000010, 6'd0, E_FETCH);

      reset = 1'b1;
      Opcode = 6'b100011;
      Funct = 6'd0;
      #7 chk("reset_held", E_FETCH);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         Opcode = vecs[i].op;
         Funct = vecs[i].fn;
         step($sformatf("vec%0d", i), vecs[i].exp);
      end

      reset = 1'b1;
      step("resync", E_FETCH);
      reset = 1'b0;
      Opcode = 6'b100011;
      step("lw2_fetch", E_FETCH);
      step("lw2_decode", E_DECODE);
      step("lw2_memadr", E_MEMADR);
      #1 chk("lw2_memrd", E_MEMRD);
      #1 reset = 1'b1;
      #1 chk("async_reset", E_FETCH);
      @(negedge clk);
      chk("reset_over_edge", E_FETCH);
      reset = 1'b0;
      step("after_abort_fetch", E_FETCH);
      step("after_abort_decode", E_DECODE);
      step("after_abort_memadr", E_MEMADR);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
